mem_arbiter: RTL and testbench

- Shares the single-port instruction/data memory (MEM: 9-bit word address, 16-bit data, synchronous read) between two requesters.
- Port 0 is the CPU (fetch, LDR, STR); port 1 is the debug/loader port used to preload or inspect memory while the CPU runs or is halted.
- The arbiter serialises accesses, drives the memory control signals, and returns read data with a valid pulse to the winning requester.

---
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter for the shared single-port instruction/data memory
//
// Purpose: serialises memory accesses from port 0 (CPU) and port 1 (debug/loader),
// drives the memory control signals and returns read data with a one-cycle valid pulse
// to the port that issued the read.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   pN_req/we/addr/wdata       port N request, held stable until pN_gnt
//   pN_gnt                     port N request accepted this cycle (combinational)
//   pN_rvalid/pN_rdata         port N read data valid pulse / registered read data
//   mem_addr/mem_din           memory address / write data
//   mem_write                  memory write strobe, commits at the closing edge
//   mem_dout                   memory read data, valid RD_LAT cycles after the address
//   busy                       high while a read is in flight
module mem_arbiter #(
  parameter int AW        = 9,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_write,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] RWAIT = 1'b1;
  localparam logic [2:0] LAT3  = 3'(RD_LAT);

  logic [0:0]    state;
  logic [2:0]    cnt;
  logic          last;   // port granted most recently
  logic          owner;  // port that owns the in-flight read
  logic [AW-1:0] addr_q;
  logic [DW-1:0] din_q;

  logic          issue;
  logic          win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Under contention round-robin hands the grant to the port that did not win last.
  always_comb begin
    win = 1'b0;
    if (p0_req && p1_req)
      win = (FIXED_PRI != 0) ? 1'b0 : ~last;
    else if (p1_req)
      win = 1'b1;
  end

  // Gated by reset so every output reads zero the moment reset rises.
  assign issue     = !reset && (state == IDLE) && (p0_req || p1_req);

  assign win_we    = win ? p1_we    : p0_we;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;

  assign p0_gnt    = issue && !win;
  assign p1_gnt    = issue && win;
  assign mem_write = issue && win_we;

  // The winner's address is presented in the issue cycle itself; the registered
  // copy holds it afterwards (through RWAIT and while idle).
  assign mem_addr  = issue ? win_addr  : addr_q;
  assign mem_din   = issue ? win_wdata : din_q;
  assign busy      = (state == RWAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      last      <= 1'b1;
      owner     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      if (issue) begin
        last   <= win;
        addr_q <= win_addr;
        din_q  <= win_wdata;
        // Writes finish in the issue cycle, so only reads leave IDLE.
        if (!win_we) begin
          state <= RWAIT;
          cnt   <= LAT3;
          owner <= win;
        end
      end else if (state == RWAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) begin
          state <= IDLE;
          if (owner) begin
            p1_rdata  <= mem_dout;
            p1_rvalid <= 1'b1;
          end else begin
            p0_rdata  <= mem_dout;
            p0_rvalid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk;
  logic reset;

  logic        p0_req    [3];
  logic        p0_we     [3];
  logic [8:0]  p0_addr   [3];
  logic [15:0] p0_wdata  [3];
  logic        p0_gnt    [3];
  logic        p0_rvalid [3];
  logic [15:0] p0_rdata  [3];
  logic        p1_req    [3];
  logic        p1_we     [3];
  logic [8:0]  p1_addr   [3];
  logic [15:0] p1_wdata  [3];
  logic        p1_gnt    [3];
  logic        p1_rvalid [3];
  logic [15:0] p1_rdata  [3];
  logic [8:0]  mem_addr  [3];
  logic        mem_write [3];
  logic [15:0] mem_din   [3];
  logic [15:0] mem_dout  [3];
  logic        busy      [3];

  int total;
  int bad;

  // Instance 0: defaults. Instance 1: fixed priority. Instance 2: read latency 3.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    logic [15:0] mem  [512];
    logic [15:0] pipe [4];

    mem_arbiter #(
      .AW(9), .DW(16), .RD_LAT(LAT), .FIXED_PRI((g == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req[g]), .p0_we(p0_we[g]), .p0_addr(p0_addr[g]), .p0_wdata(p0_wdata[g]),
      .p0_gnt(p0_gnt[g]), .p0_rvalid(p0_rvalid[g]), .p0_rdata(p0_rdata[g]),
      .p1_req(p1_req[g]), .p1_we(p1_we[g]), .p1_addr(p1_addr[g]), .p1_wdata(p1_wdata[g]),
      .p1_gnt(p1_gnt[g]), .p1_rvalid(p1_rvalid[g]), .p1_rdata(p1_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_write(mem_write[g]), .mem_din(mem_din[g]),
      .mem_dout(mem_dout[g]), .busy(busy[g])
    );

    initial begin
      for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
      for (int i = 0; i < 4; i++) pipe[i] = 16'h0000;
      mem[0] = 16'hD005;
      mem[5] = 16'hABCD;
    end

    // Synchronous-read memory with LAT cycles from address to data.
    always @(posedge clk) begin
      if (mem_write[g]) mem[mem_addr[g]] <= mem_din[g];
      pipe[0] <= mem[mem_addr[g]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout[g] = pipe[LAT-1];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p0_req[i] = 0; p0_we[i] = 0; p0_addr[i] = '0; p0_wdata[i] = '0;
      p1_req[i] = 0; p1_we[i] = 0; p1_addr[i] = '0; p1_wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    settle();
    chk("rst_p0_gnt",    32'(p0_gnt[0]),    0);
    chk("rst_p1_gnt",    32'(p1_gnt[0]),    0);
    chk("rst_p0_rvalid", 32'(p0_rvalid[0]), 0);
    chk("rst_p0_rdata",  32'(p0_rdata[0]),  0);
    chk("rst_mem_addr",  32'(mem_addr[0]),  0);
    chk("rst_mem_write", 32'(mem_write[0]), 0);
    chk("rst_mem_din",   32'(mem_din[0]),   0);
    chk("rst_busy",      32'(busy[0]),      0);

    // Reset in the middle of a read.
    tick();
    p0_req[0] = 1; p0_addr[0] = 9'd5;
    settle();
    chk("mid_gnt",  32'(p0_gnt[0]),   1);
    chk("mid_addr", 32'(mem_addr[0]), 5);
    tick();
    p0_req[0] = 0;
    settle();
    chk("mid_busy", 32'(busy[0]), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",   32'(busy[0]),      0);
    chk("mid_rst_addr",   32'(mem_addr[0]),  0);
    chk("mid_rst_rvalid", 32'(p0_rvalid[0]), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mid_no_rvalid", 32'(p0_rvalid[0]), 0);
      tick();
    end
    p0_req[0] = 1; p0_we[0] = 1; p0_addr[0] = 9'd10; p0_wdata[0] = 16'h0A0A;
    p1_req[0] = 1; p1_we[0] = 1; p1_addr[0] = 9'd11; p1_wdata[0] = 16'h0B0B;
    settle();
    chk("post_rst_p0_gnt", 32'(p0_gnt[0]),    1);
    chk("post_rst_p1_gnt", 32'(p1_gnt[0]),    0);
    chk("post_rst_write",  32'(mem_write[0]), 1);
    chk("post_rst_addr",   32'(mem_addr[0]),  10);
    tick();
    p0_req[0] = 0; p0_we[0] = 0; p1_req[0] = 0; p1_we[0] = 0;

    // Single read, latency 1.
    p0_req[0] = 1; p0_addr[0] = 9'd5;
    settle();
    chk("rd_gnt",    32'(p0_gnt[0]), 1);
    chk("rd_busy_n", 32'(busy[0]),   0);
    tick();
    p0_req[0] = 0;
    settle();
    chk("rd_busy_n1",   32'(busy[0]),      1);
    chk("rd_rvalid_n1", 32'(p0_rvalid[0]), 0);
    tick();
    settle();
    chk("rd_rvalid_n2", 32'(p0_rvalid[0]), 1);
    chk("rd_rdata",     32'(p0_rdata[0]),  'hABCD);
    chk("rd_busy_n2",   32'(busy[0]),      0);
    chk("rd_p1_rdata",  32'(p1_rdata[0]),  0);
    tick();
    settle();
    chk("rd_rvalid_n3", 32'(p0_rvalid[0]), 0);
    chk("rd_rdata_hold", 32'(p0_rdata[0]), 'hABCD);

    // Port 1 write.
    tick();
    p1_req[0] = 1; p1_we[0] = 1; p1_addr[0] = 9'd6; p1_wdata[0] = 16'h1234;
    settle();
    chk("wr_p1_gnt", 32'(p1_gnt[0]),    1);
    chk("wr_strobe", 32'(mem_write[0]), 1);
    chk("wr_addr",   32'(mem_addr[0]),  6);
    chk("wr_din",    32'(mem_din[0]),   'h1234);
    chk("wr_p0_gnt", 32'(p0_gnt[0]),    0);
    tick();
    p1_req[0] = 0; p1_we[0] = 0;
    settle();
    chk("wr_mem6",     32'(g_dut[0].mem[6]), 'h1234);
    chk("wr_strobe_n", 32'(mem_write[0]),    0);

    // Round-robin contention: p0 reads addr 0, p1 reads addr 5.
    tick();
    p0_req[0] = 1; p0_addr[0] = 9'd0;
    p1_req[0] = 1; p1_addr[0] = 9'd5;
    settle();
    chk("rr_c0_p0_gnt", 32'(p0_gnt[0]), 1);
    chk("rr_c0_p1_gnt", 32'(p1_gnt[0]), 0);
    tick();
    p0_req[0] = 0;
    settle();
    chk("rr_c1_p1_gnt", 32'(p1_gnt[0]), 0);
    chk("rr_c1_busy",   32'(busy[0]),   1);
    tick();
    p0_req[0] = 1;
    settle();
    chk("rr_c2_p0_rvalid", 32'(p0_rvalid[0]), 1);
    chk("rr_c2_p0_rdata",  32'(p0_rdata[0]),  'hD005);
    chk("rr_c2_p1_gnt",    32'(p1_gnt[0]),    1);
    chk("rr_c2_p0_gnt",    32'(p0_gnt[0]),    0);
    tick();
    p1_req[0] = 0;
    settle();
    chk("rr_c3_p0_gnt", 32'(p0_gnt[0]), 0);
    tick();
    p1_req[0] = 1;
    settle();
    chk("rr_c4_p1_rvalid", 32'(p1_rvalid[0]), 1);
    chk("rr_c4_p1_rdata",  32'(p1_rdata[0]),  'hABCD);
    chk("rr_c4_p0_gnt",    32'(p0_gnt[0]),    1);
    chk("rr_c4_p1_gnt",    32'(p1_gnt[0]),    0);
    tick();
    p0_req[0] = 0;
    settle();
    tick();
    p0_req[0] = 1;
    settle();
    chk("rr_c6_p0_rvalid", 32'(p0_rvalid[0]), 1);
    chk("rr_c6_p1_gnt",    32'(p1_gnt[0]),    1);
    tick();
    p0_req[0] = 0; p1_req[0] = 0;
    settle();
    tick();
    settle();
    chk("rr_c8_p1_rvalid", 32'(p1_rvalid[0]), 1);
    chk("rr_c8_p1_rdata",  32'(p1_rdata[0]),  'hABCD);

    // Readback of the port 1 write through port 0.
    tick();
    p0_req[0] = 1; p0_addr[0] = 9'd6;
    settle();
    chk("rb_gnt", 32'(p0_gnt[0]), 1);
    tick();
    p0_req[0] = 0;
    tick();
    settle();
    chk("rb_rvalid", 32'(p0_rvalid[0]), 1);
    chk("rb_rdata",  32'(p0_rdata[0]),  'h1234);

    // Fixed priority: both write continuously.
    tick();
    p0_req[1] = 1; p0_we[1] = 1; p0_addr[1] = 9'd20; p0_wdata[1] = 16'h1111;
    p1_req[1] = 1; p1_we[1] = 1; p1_addr[1] = 9'd21; p1_wdata[1] = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("fp_p0_gnt", 32'(p0_gnt[1]),   1);
      chk("fp_p1_gnt", 32'(p1_gnt[1]),   0);
      chk("fp_addr",   32'(mem_addr[1]), 20);
      tick();
    end
    p0_req[1] = 0;
    settle();
    chk("fp_p1_alone_gnt", 32'(p1_gnt[1]),   1);
    chk("fp_p1_alone_addr", 32'(mem_addr[1]), 21);
    tick();
    p1_req[1] = 0;

    // Read latency 3: p1 reads addr 5, p0 requests during RWAIT.
    p1_req[2] = 1; p1_addr[2] = 9'd5;
    settle();
    chk("l3_p1_gnt", 32'(p1_gnt[2]), 1);
    tick();
    p1_req[2] = 0;
    p0_req[2] = 1; p0_addr[2] = 9'd0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("l3_busy",      32'(busy[2]),      1);
      chk("l3_p0_gnt_w",  32'(p0_gnt[2]),    0);
      chk("l3_p1_rvalid_w", 32'(p1_rvalid[2]), 0);
      tick();
    end
    settle();
    chk("l3_busy_end",  32'(busy[2]),      0);
    chk("l3_p1_rvalid", 32'(p1_rvalid[2]), 1);
    chk("l3_p1_rdata",  32'(p1_rdata[2]),  'hABCD);
    chk("l3_p0_gnt",    32'(p0_gnt[2]),    1);
    tick();
    p0_req[2] = 0;
    repeat (3) tick();
    settle();
    chk("l3_p0_rvalid", 32'(p0_rvalid[2]), 1);
    chk("l3_p0_rdata",  32'(p0_rdata[2]),  'hD005);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
